// File: rtl/pitch_lookup_arbiter_pkg.sv
// Shared definitions for the pitch lookup arbiter: default widths and FSM encoding.
package pitch_lookup_arbiter_pkg;

  // Default note index / pitch word widths shared with the rest of the APU.
  localparam int unsigned DefNoteWidth  = 6;
  localparam int unsigned DefPitchWidth = 16;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/pitch_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after the
// pointer, wrapping around. Independent of the lookup table so it can be reused
// for other shared resources.
module pitch_lookup_arbiter_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              any_gnt_o
);

  logic [IdxW-1:0] idx;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!any_gnt_o && req_i[idx]) begin
        any_gnt_o = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = idx;
      end
    end
  end

endmodule

// File: rtl/pitch_lookup_arbiter.sv
// Shares one fixed-latency pitch table among several channel controllers.
// Requests are latched per channel, granted round-robin, one lookup in flight.
module pitch_lookup_arbiter
  import pitch_lookup_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned NOTE_WIDTH     = DefNoteWidth,
  parameter int unsigned PITCH_WIDTH    = DefPitchWidth,
  parameter int unsigned LOOKUP_LATENCY = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_CHANNELS-1:0]          i_req,
  input  logic [NUM_CHANNELS*NOTE_WIDTH-1:0] i_note,
  output logic [NUM_CHANNELS-1:0]          o_valid,
  output logic [PITCH_WIDTH-1:0]           o_pitch,
  output logic                             o_lookup_en,
  output logic [NOTE_WIDTH-1:0]            o_lookup_addr,
  input  logic [PITCH_WIDTH-1:0]           i_lookup_data,
  output logic                             o_busy
);

  localparam int unsigned PtrW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned CntW = $clog2(LOOKUP_LATENCY) + 1;

  state_e                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d, pending_clr;
  logic [NOTE_WIDTH-1:0]   note_q [NUM_CHANNELS];
  logic [NOTE_WIDTH-1:0]   note_d [NUM_CHANNELS];
  logic [PtrW-1:0]         ptr_q, ptr_d;
  logic [PtrW-1:0]         gnt_idx_q, gnt_idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PITCH_WIDTH-1:0]  pitch_q, pitch_d;

  logic [NUM_CHANNELS-1:0] arb_gnt;
  logic [PtrW-1:0]         arb_idx;
  logic                    arb_any;

  pitch_lookup_arbiter_rr_arbiter #(
    .NumReq (NUM_CHANNELS)
  ) u_rr_arbiter (
    .req_i     (pending_q),
    .ptr_i     (ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_gnt_o (arb_any)
  );

  // Latch each channel's note on its strobe; a re-strobe simply overwrites it.
  always_comb begin
    note_d = note_q;
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      if (i_req[k]) note_d[k] = i_note[k*NOTE_WIDTH +: NOTE_WIDTH];
    end
  end

  // Grant / wait / respond sequencing plus table strobe and response outputs.
  always_comb begin
    state_d       = state_q;
    pending_clr   = '0;
    ptr_d         = ptr_q;
    gnt_idx_d     = gnt_idx_q;
    cnt_d         = cnt_q;
    pitch_d       = pitch_q;
    o_lookup_en   = 1'b0;
    o_lookup_addr = '0;
    o_valid       = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          o_lookup_en   = 1'b1;
          o_lookup_addr = note_q[arb_idx];
          pending_clr   = arb_gnt;
          gnt_idx_d     = arb_idx;
          cnt_d         = CntW'(LOOKUP_LATENCY - 1);
          state_d       = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          pitch_d = i_lookup_data;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        o_valid[gnt_idx_q] = 1'b1;
        ptr_d   = (gnt_idx_q == PtrW'(NUM_CHANNELS - 1)) ? '0 : gnt_idx_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // A new strobe for the granted channel in the grant cycle survives the clear.
    pending_d = (pending_q & ~pending_clr) | i_req;
  end

  assign o_pitch = pitch_q;
  assign o_busy  = (state_q != StIdle) | (|pending_q);

  // State registers with synchronous reset; in-flight lookups are abandoned.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      note_q    <= '{default: '0};
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      cnt_q     <= '0;
      pitch_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      note_q    <= note_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      cnt_q     <= cnt_d;
      pitch_q   <= pitch_d;
    end
  end

endmodule

// File: tb/tb_pitch_lookup_arbiter.sv
// Directed bench: three builds (latency 2, 1, 4) share stimulus; each sees its
// own table model returning data exactly LOOKUP_LATENCY cycles after the strobe.
module tb_pitch_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [23:0] note;

  logic [3:0]  a_valid, b_valid, c_valid;
  logic [15:0] a_pitch, b_pitch, c_pitch;
  logic        a_en, b_en, c_en;
  logic [5:0]  a_addr, b_addr, c_addr;
  logic [15:0] a_data, b_data, c_data;
  logic        a_busy, b_busy, c_busy;

  logic        a_hen [8];
  logic        b_hen [8];
  logic        c_hen [8];
  logic [5:0]  a_hadr [8];
  logic [5:0]  b_hadr [8];
  logic [5:0]  c_hadr [8];

  int n_vec  = 0;
  int n_miss = 0;
  int n_ovl  = 0;

  int          nr, nen;
  int          rch [8];
  int          rcy [8];
  logic [15:0] rpt [8];
  logic [5:0]  enadr [8];

  always #5 clk = ~clk;

  function automatic logic [15:0] pitch_of(input logic [5:0] a);
    if (a == 6'd9) return 16'h1234;
    return 16'h5000 + 16'(a) * 16'd257;
  endfunction

  pitch_lookup_arbiter #(
    .NUM_CHANNELS(4), .NOTE_WIDTH(6), .PITCH_WIDTH(16), .LOOKUP_LATENCY(2)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_note(note), .o_valid(a_valid),
    .o_pitch(a_pitch), .o_lookup_en(a_en), .o_lookup_addr(a_addr),
    .i_lookup_data(a_data), .o_busy(a_busy)
  );

  pitch_lookup_arbiter #(
    .NUM_CHANNELS(4), .NOTE_WIDTH(6), .PITCH_WIDTH(16), .LOOKUP_LATENCY(1)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_note(note), .o_valid(b_valid),
    .o_pitch(b_pitch), .o_lookup_en(b_en), .o_lookup_addr(b_addr),
    .i_lookup_data(b_data), .o_busy(b_busy)
  );

  pitch_lookup_arbiter #(
    .NUM_CHANNELS(4), .NOTE_WIDTH(6), .PITCH_WIDTH(16), .LOOKUP_LATENCY(4)
  ) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_note(note), .o_valid(c_valid),
    .o_pitch(c_pitch), .o_lookup_en(c_en), .o_lookup_addr(c_addr),
    .i_lookup_data(c_data), .o_busy(c_busy)
  );

  // Strobe history; entry [L-1] during a cycle is the strobe from L cycles ago.
  always @(posedge clk) begin
    a_hen[0] <= a_en; a_hadr[0] <= a_addr;
    b_hen[0] <= b_en; b_hadr[0] <= b_addr;
    c_hen[0] <= c_en; c_hadr[0] <= c_addr;
    for (int i = 1; i < 8; i++) begin
      a_hen[i] <= a_hen[i-1]; a_hadr[i] <= a_hadr[i-1];
      b_hen[i] <= b_hen[i-1]; b_hadr[i] <= b_hadr[i-1];
      c_hen[i] <= c_hen[i-1]; c_hadr[i] <= c_hadr[i-1];
    end
  end

  // Off-cycle data is junk so a capture on the wrong cycle shows up.
  assign a_data = (a_hen[1] === 1'b1) ? pitch_of(a_hadr[1]) : 16'hDEAD;
  assign b_data = (b_hen[0] === 1'b1) ? pitch_of(b_hadr[0]) : 16'hDEAD;
  assign c_data = (c_hen[3] === 1'b1) ? pitch_of(c_hadr[3]) : 16'hDEAD;

  always @(negedge clk) begin
    if (a_en === 1'b1 && a_valid != 4'd0) n_ovl <= n_ovl + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int ch, input logic [5:0] n);
    req[ch] = 1'b1;
    note[ch*6 +: 6] = n;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    note = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Record DUT A responses/strobes; cycle 1 is the current cycle.
  task automatic capture(input int cycles, input bit rereq0);
    nr  = 0;
    nen = 0;
    for (int k = 0; k < 8; k++) begin
      rch[k] = -1; rcy[k] = -1; rpt[k] = '0; enadr[k] = '0;
    end
    for (int c = 1; c <= cycles; c++) begin
      if (c > 1) begin
        tick();
        req = '0;
      end
      if (a_en) begin
        if (nen < 8) enadr[nen] = a_addr;
        nen++;
      end
      if (a_valid != 4'd0) begin
        if (nr < 8) begin
          rcy[nr] = c;
          rpt[nr] = a_pitch;
          for (int k = 0; k < 4; k++) if (a_valid[k]) rch[nr] = k;
        end
        nr++;
        if (rereq0 && a_valid[0]) set_req(0, 6'd3);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          la, lb, lc, pulses;
    logic [15:0] pa, pb, pc;
    logic [3:0]  va;

    rst = 1'b1; req = '0; note = '0;
    tick();
    tick();
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_pitch", 32'(a_pitch), 32'd0);
    check("rst_en",    32'(a_en),    32'd0);
    check("rst_addr",  32'(a_addr),  32'd0);
    check("rst_busy",  32'(a_busy),  32'd0);
    rst = 1'b0;

    // Single request on ch1, note 9; latency measured on all three builds.
    set_req(1, 6'd9);
    tick();
    req = '0;
    check("t1_en",   32'(a_en),   32'd1);
    check("t1_addr", 32'(a_addr), 32'd9);
    check("t1_busy", 32'(a_busy), 32'd1);
    la = -1; lb = -1; lc = -1; pulses = 0;
    pa = '0; pb = '0; pc = '0; va = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) tick();
      if (a_valid != 4'd0) begin
        pulses++;
        if (la < 0) begin la = c; pa = a_pitch; va = a_valid; end
      end
      if (b_valid != 4'd0 && lb < 0) begin lb = c; pb = b_pitch; end
      if (c_valid != 4'd0 && lc < 0) begin lc = c; pc = c_pitch; end
    end
    check("t1_lat",    32'(la),     32'd4);
    check("t1_vec",    32'(va),     32'b0010);
    check("t1_pitch",  32'(pa),     32'h1234);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_idle",   32'(a_busy), 32'd0);
    check("l1_lat",    32'(lb),     32'd3);
    check("l1_pitch",  32'(pb),     32'h1234);
    check("l4_lat",    32'(lc),     32'd6);
    check("l4_pitch",  32'(pc),     32'h1234);

    // All four channels at once from pointer 0.
    do_reset();
    for (int k = 0; k < 4; k++) set_req(k, 6'(10 + k));
    tick();
    req = '0;
    capture(20, 1'b0);
    check("t2_count", 32'(nr), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_ch%0d", k),    32'(rch[k]), 32'(k));
      check($sformatf("t2_cyc%0d", k),   32'(rcy[k]), 32'(4 + 4 * k));
      check($sformatf("t2_pitch%0d", k), 32'(rpt[k]), 32'(pitch_of(6'(10 + k))));
    end

    // Fairness: ch0 keeps re-requesting, ch2 asks once.
    do_reset();
    set_req(0, 6'd3);
    tick();
    req = '0;
    set_req(2, 6'd20);
    capture(12, 1'b1);
    check("t3_count",  32'(nr),     32'd3);
    check("t3_first",  32'(rch[0]), 32'd0);
    check("t3_second", 32'(rch[1]), 32'd2);
    check("t3_pitch2", 32'(rpt[1]), 32'(pitch_of(6'd20)));
    check("t3_third",  32'(rch[2]), 32'd0);

    // Re-strobe ch3 (5 then 7) while ch0 holds the table.
    do_reset();
    set_req(0, 6'd1);
    tick();
    req = '0;
    set_req(3, 6'd5);
    tick();
    req = '0;
    set_req(3, 6'd7);
    capture(14, 1'b0);
    check("t4_nen",   32'(nen),      32'd1);
    check("t4_addr",  32'(enadr[0]), 32'd7);
    check("t4_count", 32'(nr),       32'd2);
    check("t4_ch",    32'(rch[1]),   32'd3);
    check("t4_cyc",   32'(rcy[1]),   32'd7);
    check("t4_pitch", 32'(rpt[1]),   32'(pitch_of(6'd7)));

    // Reset while ch2 is waiting on the table, ch1 pending.
    do_reset();
    set_req(2, 6'd20);
    tick();
    req = '0;
    set_req(1, 6'd4);
    tick();
    req = '0;
    rst = 1'b1;
    tick();
    check("t5_valid", 32'(a_valid), 32'd0);
    check("t5_en",    32'(a_en),    32'd0);
    check("t5_addr",  32'(a_addr),  32'd0);
    check("t5_pitch", 32'(a_pitch), 32'd0);
    check("t5_busy",  32'(a_busy),  32'd0);
    rst = 1'b0;
    capture(6, 1'b0);
    check("t5_no_resp", 32'(nr),  32'd0);
    check("t5_no_en",   32'(nen), 32'd0);
    set_req(2, 6'd21);
    tick();
    req = '0;
    capture(8, 1'b0);
    check("t5_count", 32'(nr),     32'd1);
    check("t5_ch",    32'(rch[0]), 32'd2);
    check("t5_cyc",   32'(rcy[0]), 32'd4);
    check("t5_rpitch", 32'(rpt[0]), 32'(pitch_of(6'd21)));

    check("no_overlap", 32'(n_ovl), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
